dm_access_unit: RTL and testbench

//  M-stage data-memory access unit for the pipelined CPU; the store/load counterpart of the D-stage immediate extender.

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_load_ext.sv | 24 ++
 rtl/dm_access_unit.sv | 127 ++++++++++++
 tb/tb_dm_access_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size codes, FSM state encodings and byte-enable constants for the data-memory access unit
package dm_pkg;
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_R = 2'd3
  } size_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;
  localparam logic [3:0] BE_B  = 4'b0001;
  localparam logic [3:0] BE_HL = 4'b0011;
  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;
endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: selects the addressed byte/half lane of a raw read word and sign/zero-extends it to 32 bits
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsign;
  logic        w_hsign;
  assign w_byte  = i_raw[{i_a, 3'b000} +: 8];
  assign w_half  = i_a[1] ? i_raw[31:16] : i_raw[15:0];
  assign w_bsign = ~i_unsigned & w_byte[7];
  assign w_hsign = ~i_unsigned & w_half[15];
  // Reserved size falls through to the word path with the raw word unchanged
  always_comb begin
    o_data = (i_size == SZ_B) ? {{24{w_bsign}}, w_byte} :
             (i_size == SZ_H) ? {{16{w_hsign}}, w_half} : i_raw;
  end
endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: M-stage load/store unit with lane packing, req/ack memory handshake and load extension;
// define DM_ALIGN_EXC_EN to raise exc_o on misaligned half/word accesses instead of forcing them aligned
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          stall_o,
  output logic          done_o,
  output logic [DW-1:0] rdata_o,
  output logic          exc_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);
  state_e        r_state;
  state_e        w_next;
  size_e         w_size;
  logic [1:0]    w_a;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata;
  logic          w_exc;
  logic          w_start;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_a;
  logic [31:0]   w_ext;

  assign w_size = size_e'(req_size_i);

  // Force the lane offset aligned for the access size, then derive byte enables and replicated store data
  always_comb begin
    w_a     = (w_size == SZ_B) ? req_addr_i[1:0] :
              (w_size == SZ_H) ? {req_addr_i[1], 1'b0} : 2'b00;
    w_be    = (w_size == SZ_B) ? BE_B << w_a :
              (w_size == SZ_H) ? (w_a[1] ? BE_HH : BE_HL) : BE_W;
    w_wdata = (w_size == SZ_B) ? {4{req_wdata_i[7:0]}} :
              (w_size == SZ_H) ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  end

`ifdef DM_ALIGN_EXC_EN
  logic w_mis;
  // Misaligned half (odd address) or word/reserved (any low bit set) is trapped instead of issued
  always_comb begin
    w_mis = ((w_size == SZ_H) && req_addr_i[0]) ||
            ((w_size == SZ_W || w_size == SZ_R) && (req_addr_i[1:0] != 2'b00));
    w_exc = w_mis;
  end
`else
  assign w_exc = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && req_valid_i && !w_exc;
  assign stall_o = req_valid_i && (r_state != S_DONE);

  dm_load_ext u_ext (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_a        (r_a),
    .i_raw      (mem_rdata_i),
    .o_data     (w_ext)
  );

  // Next-state: DONE lasts one cycle and ignores req_valid_i so the completed instruction can advance
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = req_valid_i ? (w_exc ? S_DONE : S_BUSY) : S_IDLE;
      S_BUSY:  w_next = mem_ack_i ? S_DONE : S_BUSY;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Registered memory interface, completion pulse and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o      <= 1'b0;
      exc_o       <= 1'b0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_a         <= 2'b00;
    end else begin
      done_o <= (w_next == S_DONE);
      exc_o  <= (r_state == S_IDLE) && req_valid_i && w_exc;
      if (w_start) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= req_we_i;
        mem_be_o    <= w_be;
        mem_addr_o  <= {req_addr_i[AW-1:2], 2'b00};
        mem_wdata_o <= w_wdata;
        r_size      <= req_size_i;
        r_uns       <= req_unsigned_i;
        r_a         <= w_a;
      end
      if ((r_state == S_BUSY) && mem_ack_i) begin
        mem_req_o <= 1'b0;
        if (!mem_we_o) rdata_o <= w_ext;
      end
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: directed vectors for the data-memory access unit with hand-computed expectations
module tb_dm_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        exc_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  int          n_vec = 0;
  int          n_err = 0;

  dm_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .stall_o        (stall_o),
    .done_o         (done_o),
    .rdata_o        (rdata_o),
    .exc_o          (exc_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
  endtask

  // Runs one access from IDLE through the DONE cycle; returns with req_valid_i still high in DONE
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int dly,
                        input logic [31:0] rd, input logic [3:0] e_be,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata);
    drive(we, sz, uns, addr, wd);
    #1;
    chk({tag, "_stall_idle"}, 32'(stall_o), 32'd1);
    step();
    chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
    chk({tag, "_we"}, 32'(mem_we_o), 32'(we));
    chk({tag, "_be"}, 32'(mem_be_o), 32'(e_be));
    chk({tag, "_addr"}, mem_addr_o, e_addr);
    if (we) chk({tag, "_wdata"}, mem_wdata_o, e_wdata);
    for (int i = 0; i < dly; i++) begin
      chk({tag, "_hold_req"}, 32'(mem_req_o), 32'd1);
      chk({tag, "_hold_stall"}, 32'(stall_o), 32'd1);
      chk({tag, "_hold_done"}, 32'(done_o), 32'd0);
      chk({tag, "_hold_be"}, 32'(mem_be_o), 32'(e_be));
      step();
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hDEAD_0BAD;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_req_clr"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, "_exc"}, 32'(exc_o), 32'd0);
  endtask

  task automatic finish_req(input string tag);
    req_valid_i = 1'b0;
    step();
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_exc", 32'(exc_o), 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    access("sb", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 0, 32'h0, 4'b1000, 32'h1000, 32'hA5A5_A5A5);
    chk("sb_rdata_kept", rdata_o, 32'd0);
    finish_req("sb");
    access("sh", 1'b1, 2'd1, 1'b0, 32'h1002, 32'h1234_BEEF, 0, 32'h0, 4'b1100, 32'h1000, 32'hBEEF_BEEF);
    finish_req("sh");
    access("lb", 1'b0, 2'd0, 1'b0, 32'h1002, 32'h0, 0, 32'h80FF_0000, 4'b0100, 32'h1000, 32'h0);
    chk("lb_rdata", rdata_o, 32'hFFFF_FFFF);
    finish_req("lb");
    chk("lb_rdata_held", rdata_o, 32'hFFFF_FFFF);
    access("lbu", 1'b0, 2'd0, 1'b1, 32'h1002, 32'h0, 0, 32'h80FF_0000, 4'b0100, 32'h1000, 32'h0);
    chk("lbu_rdata", rdata_o, 32'h0000_00FF);
    finish_req("lbu");
    access("lb3", 1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 1, 32'h7F00_0000, 4'b1000, 32'h2000, 32'h0);
    chk("lb3_rdata", rdata_o, 32'h0000_007F);
    finish_req("lb3");
    access("lh", 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 0, 32'h8001_1234, 4'b1100, 32'h1000, 32'h0);
    chk("lh_rdata", rdata_o, 32'hFFFF_8001);
    finish_req("lh");
    access("lhu", 1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 0, 32'h8001_9234, 4'b0011, 32'h1000, 32'h0);
    chk("lhu_rdata", rdata_o, 32'h0000_9234);
    finish_req("lhu");
    access("lw5", 1'b0, 2'd2, 1'b0, 32'h3008, 32'h0, 5, 32'hCAFE_F00D, 4'b1111, 32'h3008, 32'h0);
    chk("lw5_rdata", rdata_o, 32'hCAFE_F00D);
    finish_req("lw5");
`ifdef DM_ALIGN_EXC_EN
    drive(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
    step();
    chk("mis_done", 32'(done_o), 32'd1);
    chk("mis_exc", 32'(exc_o), 32'd1);
    chk("mis_req", 32'(mem_req_o), 32'd0);
    chk("mis_rdata_kept", rdata_o, 32'hCAFE_F00D);
    finish_req("mis");
    chk("mis_exc_clr", 32'(exc_o), 32'd0);
`else
    access("mis", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 0, 32'h1122_3344, 4'b1111, 32'h1000, 32'h0);
    chk("mis_rdata", rdata_o, 32'h1122_3344);
    finish_req("mis");
`endif
    drive(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
    step();
    chk("rst_mid_req_before", 32'(mem_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_done", 32'(done_o), 32'd0);
    req_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555_5555;
    step();
    mem_ack_i = 1'b0;
    chk("late_ack_done", 32'(done_o), 32'd0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_rdata", rdata_o, 32'd0);
    step();
    chk("late_ack_done2", 32'(done_o), 32'd0);
    access("post_rst", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 0, 32'h0BAD_CAFE, 4'b1111, 32'h4000, 32'h0);
    chk("post_rst_rdata", rdata_o, 32'h0BAD_CAFE);
    finish_req("post_rst");
    access("b2b_sw", 1'b1, 2'd2, 1'b0, 32'h2000, 32'hDEAD_BEEF, 0, 32'h0, 4'b1111, 32'h2000, 32'hDEAD_BEEF);
    chk("b2b_sw_rdata_kept", rdata_o, 32'h0BAD_CAFE);
    drive(1'b0, 2'd2, 1'b0, 32'h2004, 32'h0);
    #1;
    chk("b2b_stall_done", 32'(stall_o), 32'd0);
    step();
    chk("b2b_idle_req", 32'(mem_req_o), 32'd0);
    chk("b2b_idle_done", 32'(done_o), 32'd0);
    chk("b2b_idle_stall", 32'(stall_o), 32'd1);
    access("b2b_lw", 1'b0, 2'd2, 1'b0, 32'h2004, 32'h0, 0, 32'h1234_5678, 4'b1111, 32'h2004, 32'h0);
    chk("b2b_lw_rdata", rdata_o, 32'h1234_5678);
    finish_req("b2b_lw");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
